inst_rom: RTL

INST_ROM -- requirements
Module: inst_rom

---
 rtl/inst_rom_pkg.sv | 15 +
 rtl/inst_rom_mem.sv | 23 ++
 rtl/inst_rom.sv | 134 +++++++++++++
 3 files changed

// File: rtl/inst_rom_pkg.sv
// Shared constants for the instruction ROM: FSM encoding, fetch NOP word and loader widths.
package inst_rom_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_READY = 2'd3
  } rom_state_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam int          LD_BYTE_W    = 8;
  localparam int          WORD_W       = 32;

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction storage: one synchronous write port, one asynchronous read port, no reset.
module inst_mem
  import inst_rom_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom.sv
// Loadable instruction ROM: assembles a big-endian byte stream into words, then serves fetches.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [LD_BYTE_W-1:0]  ld_byte,
  input  logic                  ld_end,
  output logic                  ld_ready,
  output logic                  busy,
  output logic                  loaded,
  output logic [DEPTH_LOG2:0]   word_cnt,
  output logic                  err
);

  localparam int AW = DEPTH_LOG2;

  rom_state_e  state_q, state_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        err_q, err_d;

  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] asm_next;
  logic        in_range;
  logic        accept;
  logic        addr_unused;

  assign in_range    = (addr[31:AW+2] == '0);
  assign addr_unused = ^addr[1:0];
  assign ld_ready    = (state_q == ST_LOAD) && !wptr_q[AW];
  assign accept      = ld_ready && ld_valid;
  // First byte of a word lands in [31:24]; shift = 8 * (3 - byte_cnt)
  assign asm_next    = asm_q | ({{(32-LD_BYTE_W){1'b0}}, ld_byte} << {~byte_cnt_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_wdata  = asm_q;

    if (state_q == ST_READY && ce && !in_range) err_d = 1'b1;

    if (ld_start) begin
      state_d    = ST_LOAD;
      wptr_d     = '0;
      word_cnt_d = '0;
      byte_cnt_d = '0;
      asm_d      = '0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (byte_cnt_q == 2'd3) begin
              mem_we     = 1'b1;
              mem_wdata  = asm_next;
              wptr_d     = wptr_q + (AW+1)'(1);
              word_cnt_d = word_cnt_q + (AW+1)'(1);
              byte_cnt_d = '0;
              asm_d      = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              asm_d      = asm_next;
            end
          end
          // End-of-image is judged on the byte count after this cycle's byte
          if (wptr_d[AW])  state_d = ST_READY;
          else if (ld_end) state_d = (byte_cnt_d == 2'd0) ? ST_READY : ST_FLUSH;
        end
        ST_FLUSH: begin
          mem_we     = 1'b1;
          mem_wdata  = asm_q;
          wptr_d     = wptr_q + (AW+1)'(1);
          word_cnt_d = word_cnt_q + (AW+1)'(1);
          byte_cnt_d = '0;
          asm_d      = '0;
          state_d    = ST_READY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      wptr_q     <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
    end
  end

  inst_mem #(.DEPTH_LOG2(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q[AW-1:0]),
    .wdata (mem_wdata),
    .raddr (addr[AW+1:2]),
    .rdata (mem_rdata)
  );

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign loaded   = (state_q == ST_READY);
  assign word_cnt = word_cnt_q;
  assign err      = err_q;
  assign inst     = (loaded && ce && in_range) ? mem_rdata : NOP_WORD;

endmodule
